// File: rtl/dct_pkg.sv
// Shared types and helpers for the DCT datapath stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default lane widths and rows per block, lane typedefs, and sat_s(),
// a signed clamp to a w-bit two's-complement range.
package dct_pkg;

   localparam int IN_W_DEF  = 12;
   localparam int OUT_W_DEF = 8;
   localparam int ROWS_DEF  = 4;

   typedef logic signed [IN_W_DEF-1:0]  lane_in_t;
   typedef logic signed [OUT_W_DEF-1:0] lane_out_t;

   // Clamp v into [-2**(w-1), 2**(w-1)-1]; w must be in 2..31.
   function automatic logic signed [31:0] sat_s(input logic signed [31:0] v, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/treatment_inv_lane.sv
// One lane of inverse-transform output treatment: round, arithmetic shift, clamp.
// Latency: combinational.
// Backpressure: none; the caller owns all handshaking.
// Ports: i_x signed IN_W-bit input; o_y signed OUT_W-bit clamped result; o_sat high when
// the rounded value fell outside the OUT_W range and was clamped.
module treatment_inv_lane
   import dct_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int SHIFT = 2
) (
   input  logic signed [IN_W-1:0]  i_x,
   output logic signed [OUT_W-1:0] o_y,
   output logic                    o_sat
);

   // Rounding constant: half an LSB of the shifted result, zero when SHIFT is 0.
   localparam logic signed [IN_W:0] HALF = (IN_W+1)'((1 << SHIFT) >> 1);

   logic signed [IN_W:0] w_ext;
   logic signed [IN_W:0] w_sum;
   logic signed [IN_W:0] w_r;
   logic signed [31:0]   w_r32;
   logic signed [31:0]   w_y32;

   // One bit of headroom so the rounding add never overflows.
   assign w_ext = $signed({i_x[IN_W-1], i_x});
   assign w_sum = w_ext + HALF;
   assign w_r   = w_sum >>> SHIFT;
   assign w_r32 = 32'(w_r);
   assign w_y32 = sat_s(w_r32, OUT_W);

   assign o_y   = w_y32[OUT_W-1:0];
   assign o_sat = (w_y32 != w_r32);

endmodule

// File: rtl/treatment_inv.sv
// Inverse-transform output treatment: per-lane round/shift/clamp of a 4-lane row, block-row tagging.
// Latency: 2 cycles from input handshake to out_valid; 1 row per cycle throughput.
// Backpressure: 2-stage valid/ready pipe, in_ready = !s1_full | s2 can advance (no in_valid path).
// Ports: clk/rst (sync, active high); in_valid/in_ready/in_data row input; out_valid/out_ready/
// out_data/out_last row output; sat_clr clears sat_cnt, the saturating count of clamped lanes.
module treatment_inv
   import dct_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int SHIFT = 2,
   parameter int ROWS  = ROWS_DEF,
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [3:0][IN_W-1:0]      in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [3:0][OUT_W-1:0]     out_data,
   output logic                      out_last,
   input  logic                      sat_clr,
   output logic [CNT_W-1:0]          sat_cnt
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic                   r_s1_vld;
   logic [3:0][IN_W-1:0]   r_s1_dat;
   logic                   r_out_vld;
   logic [3:0][OUT_W-1:0]  r_out_dat;
   logic [RW-1:0]          r_row;
   logic [CNT_W-1:0]       r_sat_cnt;

   logic                   w_s2_adv;
   logic                   w_s1_adv;
   logic                   w_s1_xfer;
   logic [3:0][OUT_W-1:0]  w_y;
   logic [3:0]             w_sat;
   logic [2:0]             w_nsat;
   logic [CNT_W:0]         w_cnt_sum;

   assign w_s2_adv  = !r_out_vld | out_ready;
   assign w_s1_adv  = !r_s1_vld | w_s2_adv;
   assign w_s1_xfer = r_s1_vld & w_s2_adv;

   // S1 holds the raw row; round and clamp are evaluated between S1 and the output
   // registers, so the clamp flags line up with the S1->S2 transfer that counts them.
   for (genvar g = 0; g < 4; g++) begin : g_lane
      treatment_inv_lane #(
         .IN_W  (IN_W),
         .OUT_W (OUT_W),
         .SHIFT (SHIFT)
      ) u_lane (
         .i_x   (r_s1_dat[g]),
         .o_y   (w_y[g]),
         .o_sat (w_sat[g])
      );
   end

   assign w_nsat    = 3'(w_sat[0]) + 3'(w_sat[1]) + 3'(w_sat[2]) + 3'(w_sat[3]);
   assign w_cnt_sum = {1'b0, r_sat_cnt} + (CNT_W+1)'(w_nsat);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_dat  <= '0;
         r_out_vld <= 1'b0;
         r_out_dat <= '0;
         r_row     <= '0;
         r_sat_cnt <= '0;
      end else begin
         if (w_s1_adv) begin
            r_s1_vld <= in_valid;
            if (in_valid)
               r_s1_dat <= in_data;
         end
         if (w_s2_adv) begin
            r_out_vld <= r_s1_vld;
            if (r_s1_vld)
               r_out_dat <= w_y;
         end
         if (r_out_vld && out_ready)
            r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
         // Clear wins over a same-cycle increment; the sum saturates instead of wrapping.
         if (sat_clr)
            r_sat_cnt <= '0;
         else if (w_s1_xfer)
            r_sat_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
      end
   end

   assign in_ready  = w_s1_adv;
   assign out_valid = r_out_vld;
   assign out_data  = r_out_dat;
   assign out_last  = r_out_vld & (r_row == RW'(ROWS - 1));
   assign sat_cnt   = r_sat_cnt;

endmodule
